// File: rtl/count_ctrl.sv
// Run/pause/clear controller for a 4-digit BCD counter: owns the count-step
// prescaler, the BCD up/down sequencing and the 7-segment digit scan.
module count_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter bit WRAP_EN  = 1'b1
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart,
    input  logic        istop,
    input  logic        iclear,
    input  logic        iup,
    output logic [15:0] obcd,
    output logic        orunning,
    output logic        owrap,
    output logic [3:0]  odigit_sel,
    output logic [3:0]  odigit
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic          tick_end;
    logic          step;
    logic          at_limit;
    logic [15:0]   bcd_next;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A step needs an uninterrupted RUN cycle; clear or stop on the wrap edge cancels it.
    assign tick_end = (tick_cnt == TICK_MAX);
    assign step     = (state == RUN) && !iclear && !istop && tick_end;
    assign at_limit = iup ? (obcd == 16'h9999) : (obcd == 16'h0000);
    assign bcd_next = iup ? bcd_inc(obcd) : bcd_dec(obcd);

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (iclear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (!istop && istart) state_next = RUN;
                RUN: begin
                    if (istop) begin
                        state_next = PAUSE;
                    end else if (step && at_limit && !WRAP_EN) begin
                        state_next = DONE;
                    end
                end
                PAUSE:   if (!istop && istart) state_next = RUN;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        orunning = (state == RUN);
    end

    // Prescaler freezes while paused (and on the stop edge) so the phase survives resume.
    always_ff @(posedge iclk) begin
        if (irst || iclear) begin
            tick_cnt <= '0;
        end else if (state == IDLE && istart) begin
            tick_cnt <= '0;
        end else if (state == RUN && !istop) begin
            tick_cnt <= tick_end ? '0 : tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge iclk) begin
        if (irst || iclear) begin
            obcd  <= 16'h0000;
            owrap <= 1'b0;
        end else begin
            owrap <= step && at_limit;
            if (step && !(at_limit && !WRAP_EN)) begin
                obcd <= bcd_next;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            scan_cnt   <= '0;
            odigit_sel <= 4'b0001;
        end else if (scan_cnt == SCAN_MAX) begin
            scan_cnt   <= '0;
            odigit_sel <= {odigit_sel[2:0], odigit_sel[3]};
        end else begin
            scan_cnt   <= scan_cnt + SW'(1);
        end
    end

    always_comb begin
        odigit = obcd[3:0];
        unique case (odigit_sel)
            4'b0010: odigit = obcd[7:4];
            4'b0100: odigit = obcd[11:8];
            4'b1000: odigit = obcd[15:12];
            default: odigit = obcd[3:0];
        endcase
    end

endmodule
